mda_adc_scheduler: RTL and testbench
====================================

MDA_ADC_SCHEDULER -- requirements
Module: mda_adc_scheduler

Interface
REQ-001 Parameter: DISCARD, 2, dummy conversions issued after a channel change before a result is kept (0..3).
REQ-002 Parameter: TIMEOUT, 1024, max cycles from oCONV_START to iCONV_DONE before abort.
REQ-003 iCLK  in  1  sole clock; all logic on rising edge.
REQ-004 iRST  in  1  synchronous, active-high reset.
REQ-005 iEN_MASK  in  8  per-channel enable for periodic scan.
REQ-006 iPERIOD  in  16  scan period in iCLK cycles; 0 disables periodic scan.
REQ-007 iREQ  in  8  one-shot on-demand request per channel, level sampled each cycle.
REQ-008 oCONV_START  out  1  one-cycle start pulse to the conversion engine.
REQ-009 oCONV_CH  out  3  channel for the requested conversion, held stable from START until DONE.
REQ-010 iCONV_DONE  in  1  one-cycle completion pulse from the conversion engine.
REQ-011 iCONV_DATA  in  12  conversion result, valid with iCONV_DONE.
REQ-012 oSAMPLE_VALID  out  1  one-cycle pulse, kept result available.
REQ-013 oSAMPLE_CH  out  3  channel of the kept result.
REQ-014 oSAMPLE_DATA  out  12  kept result; holds until next oSAMPLE_VALID.
REQ-015 oBUSY  out  1  high whenever state is not IDLE.
REQ-016 oSCAN_DONE  out  1  one-cycle pulse after last enabled channel of a scan is kept.
REQ-017 oOVERRUN  out  1  one-cycle pulse, period tick arrived while a scan was still pending or active.
REQ-018 oTIMEOUT  out  1  one-cycle pulse, conversion aborted by timeout.

Function
REQ-019 Period counter: counts 0..iPERIOD-1, wraps, emits tick at wrap; iPERIOD=0 holds counter at 0, no ticks.
REQ-020 Tick with no scan pending/active: latch scan mask = iEN_MASK; tick otherwise: drop it, pulse oOVERRUN.
REQ-021 Pending request register: bit set by iREQ, cleared when that channel's result is kept; set wins over clear in the same cycle.
REQ-022 FSM states: IDLE, START, WAIT, DONE.
REQ-023 IDLE: on-demand pending has priority over scan; lowest-numbered pending channel first; then lowest-numbered remaining scan-mask channel.
REQ-024 IDLE -> START next cycle when any work exists; START drives oCONV_START for exactly one cycle, -> WAIT.
REQ-025 WAIT: iCONV_DONE -> DONE; TIMEOUT cycles without DONE -> oTIMEOUT, -> IDLE, channel stays pending, discard count reloaded.
REQ-026 DONE: if discard counter nonzero, decrement, result dropped, -> START same channel; else pulse oSAMPLE_VALID, update oSAMPLE_*, clear channel's pending and scan-mask bits, -> IDLE.
REQ-027 Discard counter loads DISCARD when selected channel differs from last converted channel; 0 when same.
REQ-028 oSCAN_DONE pulses same cycle as oSAMPLE_VALID that clears the last scan-mask bit; empty iEN_MASK at tick: oSCAN_DONE pulses next cycle, no conversion.
REQ-029 A channel in both pending and scan mask is converted once; both bits clear.
REQ-030 iEN_MASK / iPERIOD changes mid-scan do not affect the latched scan mask.
REQ-031 iCONV_DONE outside WAIT is ignored.
REQ-032 Minimum latency, same-channel request from IDLE: iREQ cycle N -> oCONV_START N+2.

Reset
REQ-033 iRST: state IDLE, counters 0, pending/scan mask 0, last channel 0, discard 0; all pulses 0, oCONV_CH 0, oSAMPLE_DATA 0, oSAMPLE_CH 0, oBUSY 0.
REQ-034 iRST mid-conversion aborts without oSAMPLE_VALID; a late iCONV_DONE is ignored.

Structure
REQ-035 Shared package mda_adc_pkg holds the FSM state enum, NUM_CH=8, CH_W=3, DATA_W=12.
REQ-036 Sub-module mda_adc_prio_pick: combinational lowest-set-bit picker on 8 bits, instantiated twice (pending, scan).

Verification
REQ-037 DISCARD=2, iREQ[5] pulse, engine returns 0x111,0x222,0x333 -> three starts on ch5, one oSAMPLE_VALID ch5 data 0x333.
REQ-038 iPERIOD=100, iEN_MASK=0x81, engine DONE after 20 cycles -> ch0 then ch7 kept, oSCAN_DONE once per 100-cycle period.
REQ-039 Scan active on ch0, iREQ[3] asserted -> ch3 converted before ch7; ch3 pending clears.
REQ-040 iPERIOD=10, engine latency 50 -> oOVERRUN pulses, at most one scan in flight.
REQ-041 Engine never returns DONE, TIMEOUT=1024 -> oTIMEOUT 1024 cycles after START, channel retried.
REQ-042 iRST asserted in WAIT, then iCONV_DONE -> outputs at reset values, no oSAMPLE_VALID.

Source files
------------

// File: rtl/mda_adc_pkg.sv
// Shared types and sizes for the ADC conversion scheduler.
package mda_adc_pkg;
  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;
  localparam int DATA_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [NUM_CH-1:0] ch_bit(input logic [CH_W-1:0] ch);
    logic [NUM_CH-1:0] b;
    b     = '0;
    b[ch] = 1'b1;
    return b;
  endfunction
endpackage

// File: rtl/mda_adc_scheduler_if.sv
// Conversion-engine handshake and kept-sample output of the scheduler.
interface mda_adc_scheduler_if;
  import mda_adc_pkg::*;

  logic              oCONV_START;
  logic [CH_W-1:0]   oCONV_CH;
  logic              iCONV_DONE;
  logic [DATA_W-1:0] iCONV_DATA;
  logic              oSAMPLE_VALID;
  logic [CH_W-1:0]   oSAMPLE_CH;
  logic [DATA_W-1:0] oSAMPLE_DATA;

  modport master (
    output oCONV_START, oCONV_CH, oSAMPLE_VALID, oSAMPLE_CH, oSAMPLE_DATA,
    input  iCONV_DONE, iCONV_DATA
  );

  modport slave (
    input  oCONV_START, oCONV_CH, oSAMPLE_VALID, oSAMPLE_CH, oSAMPLE_DATA,
    output iCONV_DONE, iCONV_DATA
  );
endinterface

// File: rtl/mda_adc_prio_pick.sv
// Lowest-set-bit picker over the channel vector.
module mda_adc_prio_pick
  import mda_adc_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  output logic              any,
  output logic [CH_W-1:0]   idx
);
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) idx = CH_W'(i);
    end
  end
endmodule

// File: rtl/mda_adc_scheduler.sv
// ADC conversion scheduler: periodic scan plus on-demand requests, with
// post-channel-change discard conversions and a conversion timeout.
//   state    | meaning
//   ST_IDLE  | pick next channel (on-demand first, then scan mask)
//   ST_START | one-cycle start pulse to the engine
//   ST_WAIT  | wait for engine done or timeout
//   ST_DONE  | drop result (discard pending) or keep it
module mda_adc_scheduler
  import mda_adc_pkg::*;
#(
  parameter int DISCARD = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [NUM_CH-1:0] iEN_MASK,
  input  logic [15:0]       iPERIOD,
  input  logic [NUM_CH-1:0] iREQ,
  mda_adc_scheduler_if.master conv,
  output logic              oBUSY,
  output logic              oSCAN_DONE,
  output logic              oOVERRUN,
  output logic              oTIMEOUT
);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [15:0]       per_cnt;
  logic              tick;
  logic [NUM_CH-1:0] pend, scan;
  logic              pend_any, scan_any, work;
  logic [CH_W-1:0]   pend_ch, scan_ch, pick_ch, cur_ch, last_ch;
  logic [1:0]        disc;
  logic              reload;
  logic [TMO_W-1:0]  tmo;
  logic              scan_empty;
  logic              conv_start, keep;
  logic [CH_W-1:0]   sample_ch;
  logic [DATA_W-1:0] sample_data;

  mda_adc_prio_pick u_pick_pend (.req(pend), .any(pend_any), .idx(pend_ch));
  mda_adc_prio_pick u_pick_scan (.req(scan), .any(scan_any), .idx(scan_ch));

  assign tick    = (iPERIOD != 16'd0) && (per_cnt >= iPERIOD - 16'd1);
  assign work    = pend_any | scan_any;
  assign pick_ch = pend_any ? pend_ch : scan_ch;

  always_ff @(posedge iCLK) begin
    if (iRST) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    conv_start = 1'b0;
    oTIMEOUT   = 1'b0;
    keep       = 1'b0;
    case (state)
      ST_IDLE:  if (work) state_nxt = ST_START;
      ST_START: begin
        conv_start = 1'b1;
        state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        if (conv.iCONV_DONE) begin
          state_nxt = ST_DONE;
        end else if (tmo == '0) begin
          oTIMEOUT  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (disc != 2'd0) begin
          state_nxt = ST_START;
        end else begin
          keep      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      per_cnt     <= '0;
      pend        <= '0;
      scan        <= '0;
      scan_empty  <= 1'b0;
      cur_ch      <= '0;
      last_ch     <= '0;
      disc        <= '0;
      reload      <= 1'b0;
      tmo         <= '0;
      sample_ch   <= '0;
      sample_data <= '0;
    end else begin
      if (iPERIOD == 16'd0 || tick) per_cnt <= '0;
      else                          per_cnt <= per_cnt + 16'd1;

      // A new request for the channel being kept survives the clear.
      pend <= (pend & ~(keep ? ch_bit(cur_ch) : '0)) | iREQ;

      if (tick && !scan_any) scan <= iEN_MASK;
      else if (keep)         scan <= scan & ~ch_bit(cur_ch);
      scan_empty <= tick && !scan_any && (iEN_MASK == '0);

      case (state)
        ST_IDLE: begin
          if (work) begin
            cur_ch  <= pick_ch;
            last_ch <= pick_ch;
            disc    <= (pick_ch != last_ch || reload) ? 2'(DISCARD) : 2'd0;
            reload  <= 1'b0;
          end
        end
        ST_START: tmo <= TMO_W'(TIMEOUT - 1);
        ST_WAIT: begin
          if (conv.iCONV_DONE) begin
            if (disc == 2'd0) begin
              sample_ch   <= cur_ch;
              sample_data <= conv.iCONV_DATA;
            end
          end else if (tmo == '0) begin
            reload <= 1'b1;
            disc   <= 2'(DISCARD);
          end else begin
            tmo <= tmo - TMO_W'(1);
          end
        end
        ST_DONE: if (disc != 2'd0) disc <= disc - 2'd1;
        default: ;
      endcase
    end
  end

  assign conv.oCONV_START   = conv_start;
  assign conv.oCONV_CH      = cur_ch;
  assign conv.oSAMPLE_VALID = keep;
  assign conv.oSAMPLE_CH    = sample_ch;
  assign conv.oSAMPLE_DATA  = sample_data;
  assign oBUSY      = (state != ST_IDLE);
  assign oOVERRUN   = tick && scan_any;
  assign oSCAN_DONE = (keep && (scan == ch_bit(cur_ch))) || scan_empty;
endmodule

// File: tb/tb_mda_adc_scheduler.sv
// Scoreboard bench for mda_adc_scheduler with a behavioural conversion engine.
module tb_mda_adc_scheduler;
  import mda_adc_pkg::*;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic [7:0]  iEN_MASK = '0;
  logic [7:0]  iREQ = '0;
  logic [15:0] iPERIOD = '0;
  logic        oBUSY, oSCAN_DONE, oOVERRUN, oTIMEOUT;

  mda_adc_scheduler_if cif();

  mda_adc_scheduler #(.DISCARD(2), .TIMEOUT(1024)) dut (
    .iCLK(iCLK), .iRST(iRST), .iEN_MASK(iEN_MASK), .iPERIOD(iPERIOD),
    .iREQ(iREQ), .conv(cif), .oBUSY(oBUSY), .oSCAN_DONE(oSCAN_DONE),
    .oOVERRUN(oOVERRUN), .oTIMEOUT(oTIMEOUT)
  );

  initial forever #5 iCLK = ~iCLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [14:0] sb[$];
  int start_cnt, scan_done_cnt, ovr_cnt, tmo_cnt, sample_cnt;
  int start_ch_cnt [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_counts();
    start_cnt = 0; scan_done_cnt = 0; ovr_cnt = 0; tmo_cnt = 0;
    for (int i = 0; i < 8; i++) start_ch_cnt[i] = 0;
  endtask

  task automatic exp_push(input logic [2:0] ch, input logic [11:0] data);
    sb.push_back({ch, data});
  endtask

  task automatic drain(input string name, input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(negedge iCLK);
      n++;
    end
    check(name, sb.size(), 0);
    repeat (3) @(negedge iCLK);
  endtask

  task automatic wait_start(input string name, input int maxc);
    int n = 0;
    while (!cif.oCONV_START && n < maxc) begin
      @(negedge iCLK);
      n++;
    end
    check(name, cif.oCONV_START, 1);
  endtask

  always @(posedge iCLK) cyc <= cyc + 1;

  // Conversion engine: answers each start after eng_lat cycles.
  int          eng_lat   = 20;
  bit          eng_never = 1'b0;
  logic [11:0] eng_q[$];
  initial begin
    logic [2:0] ch;
    cif.iCONV_DONE = 1'b0;
    cif.iCONV_DATA = '0;
    forever begin
      @(negedge iCLK);
      if (cif.oCONV_START === 1'b1 && !eng_never) begin
        ch = cif.oCONV_CH;
        repeat (eng_lat) @(negedge iCLK);
        cif.iCONV_DONE = 1'b1;
        if (eng_q.size() != 0) cif.iCONV_DATA = eng_q.pop_front();
        else                   cif.iCONV_DATA = {9'h140, ch};
        @(negedge iCLK);
        cif.iCONV_DONE = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every kept sample.
  always @(negedge iCLK) begin
    if (!iRST) begin
      if (cif.oCONV_START) begin
        start_cnt++;
        start_ch_cnt[cif.oCONV_CH]++;
      end
      if (oSCAN_DONE) scan_done_cnt++;
      if (oOVERRUN)   ovr_cnt++;
      if (oTIMEOUT)   tmo_cnt++;
      if (cif.oSAMPLE_VALID) begin
        sample_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_sample", {17'd0, cif.oSAMPLE_CH, cif.oSAMPLE_DATA}, 32'hFFFF);
        end else begin
          check("sample", {17'd0, cif.oSAMPLE_CH, cif.oSAMPLE_DATA}, {17'd0, sb.pop_front()});
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int t_start, t_tmo, s_before;
    clr_counts();
    sample_cnt = 0;
    repeat (3) @(negedge iCLK);
    iRST = 1'b0;
    @(negedge iCLK);
    check("rst_pulses", {cif.oCONV_START, cif.oSAMPLE_VALID, oSCAN_DONE, oOVERRUN, oTIMEOUT, oBUSY}, 0);
    check("rst_conv_ch", cif.oCONV_CH, 0);
    check("rst_sample", {cif.oSAMPLE_CH, cif.oSAMPLE_DATA}, 0);

    // Channel change from ch0 to ch5: two dropped conversions, third kept.
    eng_lat = 3;
    eng_q.push_back(12'h111); eng_q.push_back(12'h222); eng_q.push_back(12'h333);
    exp_push(3'd5, 12'h333);
    clr_counts();
    iREQ = 8'h20;
    @(negedge iCLK);
    iREQ = 8'h00;
    drain("discard_drain", 100);
    check("discard_starts", start_ch_cnt[5], 3);

    // Same channel again: no discards, start two cycles after the request.
    exp_push(3'd5, 12'hA05);
    clr_counts();
    iREQ = 8'h20;
    @(negedge iCLK);
    iREQ = 8'h00;
    check("lat_n1_no_start", cif.oCONV_START, 0);
    @(negedge iCLK);
    check("lat_n2_start", {cif.oCONV_START, cif.oCONV_CH}, {1'b1, 3'd5});
    drain("same_ch_drain", 50);
    check("same_ch_starts", start_cnt, 1);

    // Periodic scan of ch0/ch7, mask change mid-scan ignored.
    eng_lat = 20;
    iEN_MASK = 8'h81;
    exp_push(3'd0, 12'hA00);
    exp_push(3'd7, 12'hA07);
    clr_counts();
    iPERIOD = 16'd100;
    repeat (150) @(negedge iCLK);
    iEN_MASK = 8'hFF;
    repeat (100) @(negedge iCLK);
    iPERIOD = 16'd0;
    iEN_MASK = 8'h81;
    check("scan_samples_left", sb.size(), 0);
    check("scan_done_once", scan_done_cnt, 1);
    check("scan_overrun", ovr_cnt, 1);
    drain("scan_drain", 10);

    // On-demand ch3 arriving mid-scan goes before ch7.
    exp_push(3'd0, 12'hA00);
    exp_push(3'd3, 12'hA03);
    exp_push(3'd7, 12'hA07);
    clr_counts();
    iPERIOD = 16'd100;
    repeat (110) @(negedge iCLK);
    iREQ = 8'h08;
    @(negedge iCLK);
    iREQ = 8'h00;
    repeat (139) @(negedge iCLK);
    iPERIOD = 16'd0;
    drain("prio_drain", 200);
    check("prio_ch3_starts", start_ch_cnt[3], 3);
    check("prio_scan_done", scan_done_cnt, 1);

    // Short period with slow engine: overruns, one scan at a time.
    eng_lat = 50;
    iEN_MASK = 8'h01;
    for (int i = 0; i < 4; i++) exp_push(3'd0, 12'hA00);
    clr_counts();
    iPERIOD = 16'd10;
    repeat (300) @(negedge iCLK);
    iPERIOD = 16'd0;
    drain("ovr_drain", 200);
    check("ovr_count", ovr_cnt, 26);
    check("ovr_scan_done", scan_done_cnt, 4);
    iEN_MASK = 8'h00;

    // Engine never answers: timeout after 1024 cycles, then retry.
    eng_lat = 4;
    eng_never = 1'b1;
    exp_push(3'd2, 12'hA02);
    clr_counts();
    iREQ = 8'h04;
    @(negedge iCLK);
    iREQ = 8'h00;
    wait_start("tmo_first_start", 10);
    t_start = cyc;
    for (int n = 0; n < 1100 && !oTIMEOUT; n++) @(negedge iCLK);
    check("tmo_seen", oTIMEOUT, 1);
    t_tmo = cyc;
    check("tmo_delay", t_tmo - t_start, 1024);
    eng_never = 1'b0;
    @(negedge iCLK);
    wait_start("tmo_retry_start", 10);
    check("tmo_retry_delay", cyc - t_tmo, 2);
    check("tmo_retry_ch", cif.oCONV_CH, 2);
    drain("tmo_drain", 200);
    check("tmo_count", tmo_cnt, 1);

    // Reset during WAIT, then a late done from the engine.
    eng_lat = 20;
    s_before = sample_cnt;
    iREQ = 8'h10;
    @(negedge iCLK);
    iREQ = 8'h00;
    wait_start("rst_wait_start", 10);
    repeat (5) @(negedge iCLK);
    iRST = 1'b1;
    repeat (2) @(negedge iCLK);
    iRST = 1'b0;
    clr_counts();
    repeat (30) @(negedge iCLK);
    check("rstw_busy", oBUSY, 0);
    check("rstw_conv_ch", cif.oCONV_CH, 0);
    check("rstw_sample", {cif.oSAMPLE_CH, cif.oSAMPLE_DATA}, 0);
    check("rstw_no_sample", sample_cnt - s_before, 0);
    check("rstw_no_start", start_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
